imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory of the single-cycle RV32I core from a byte stream. It accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words. It writes each word to the instruction-memory write port at consecutive word addresses starting at 0. While loading, it holds the core in reset, and it releases the core when the programmed word count has been written.

---
 rtl/loader_pkg.sv | 14 +
 rtl/imem_loader_word_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 101 ++++++++++
 tb/tb_imem_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs bytes little-endian into a 32-bit word; byte 0 lands in bits [7:0].
module word_assembler
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear_i,
    input  logic                  shift_en_i,
    input  logic [7:0]            byte_i,
    output logic [31:0]           word_o,
    output logic [BYTE_IDX_W-1:0] byte_idx_o,
    output logic                  word_full_o
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [31:0]           word_q;
    logic [BYTE_IDX_W-1:0] idx_q;
    logic                  full_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            // Word contents are kept; only the lane pointer restarts.
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (shift_en_i) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_i;
            idx_q                        <= idx_q + 1'b1;
            full_q                       <= (idx_q == LAST_IDX);
        end
    end

    assign word_o      = word_q;
    assign byte_idx_o  = idx_q;
    assign word_full_o = full_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core in
// reset until the requested number of words has been written.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]       MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX  = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    loader_state_t         state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W:0]       count_q;
    logic [ADDR_W:0]       len_q;

    logic [ADDR_W:0]       count_d;
    logic [ADDR_W:0]       len_d;
    logic                  start_ok;
    logic                  handshake;
    logic                  last_byte;
    logic                  asm_clear;
    logic [31:0]           asm_word;
    logic [BYTE_IDX_W-1:0] asm_idx;
    logic                  asm_full;

    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign handshake = in_valid && in_ready;
    assign last_byte = handshake && (asm_idx == LAST_IDX);
    assign asm_clear = start_ok || (state_q == WRITE);
    assign count_d   = count_q + 1'b1;
    // Saturate so the address counter can never wrap into already-loaded words.
    assign len_d     = (len_words > MAX_WORDS) ? MAX_WORDS : len_words;

    word_assembler u_asm (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear_i     (asm_clear),
        .shift_en_i  (handshake),
        .byte_i      (in_data),
        .word_o      (asm_word),
        .byte_idx_o  (asm_idx),
        .word_full_o (asm_full)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        addr_q  <= '0;
                        count_q <= '0;
                        len_q   <= len_d;
                        state_q <= (len_words == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (last_byte) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    addr_q  <= addr_q + 1'b1;
                    count_q <= count_d;
                    state_q <= (count_d == len_q) ? DONE : LOAD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign imem_we    = (state_q == WRITE) && asm_full;
    assign imem_addr  = addr_q;
    assign imem_wdata = asm_word;
    assign busy       = (state_q == LOAD) || (state_q == WRITE);
    assign core_hold  = busy;
    assign done       = (state_q == DONE);
    assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, stalls, clamp, reset and reload.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [8:0]  len_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic [8:0]  word_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  prog[8] = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00};

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .len_words  (len_words),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (n_rst && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_reset(input int n);
        n_rst = 1'b0;
        repeat (n) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic do_start(input logic [8:0] len);
        start     = 1'b1;
        len_words = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !got; k++) begin
            if (in_ready) got = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: byte %h never accepted", b);
        end
    endtask

    task automatic send_prog(input int first, input int n);
        for (int i = first; i < first + n; i++) send_byte(prog[i]);
    endtask

    task automatic wait_done(input int budget, output int at_cyc, output logic hold_before);
        hold_before = core_hold;
        for (int k = 0; k < budget && !done; k++) begin
            hold_before = core_hold;
            @(negedge clk);
        end
        at_cyc = cyc;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done timeout: done=%b after %0d cycles", done, budget);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; len_words = '0; in_valid = 1'b1; in_data = 8'h55;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, core_hold, busy, done} !== 5'b0 || imem_addr !== 8'h00 ||
            imem_wdata !== 32'h0 || word_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/we/hold/busy/done=%b addr=%h wdata=%h cnt=%0d required all 0",
                     {in_ready, imem_we, core_hold, busy, done}, imem_addr, imem_wdata, word_count);
        end
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL idle_no_accept: in_ready=%b writes=%0d required 0/0", in_ready, wr_addr.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int c0, cd;
        logic hb;
        clear_log();
        do_start(9'd2);
        c0 = cyc;
        checks++;
        if ({busy, in_ready, core_hold} !== 3'b111) begin
            errors++;
            $display("FAIL basic_start: busy/ready/hold=%b required 111", {busy, in_ready, core_hold});
        end
        send_prog(0, 8);
        wait_done(30, cd, hb);
        checks++;
        if (cd - c0 != 10 || hb !== 1'b1 || core_hold !== 1'b0) begin
            errors++;
            $display("FAIL basic_timing: cycles=%0d hold_before=%b hold=%b required 10/1/0", cd - c0, hb, core_hold);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL basic_count: writes=%0d required 2", wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00A00093 ||
                     wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00500113) begin
            errors++;
            $display("FAIL basic_words: %h@%h %h@%h required 00A00093@00 00500113@01",
                     wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
        end
        checks++;
        if (word_count !== 9'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_wc: word_count=%0d busy=%b required 2/0", word_count, busy);
        end
    endtask

    task automatic test_stall_reload();
        int c0, cd;
        logic hb;
        clear_log();
        do_start(9'd2);
        c0 = cyc;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || imem_addr !== 8'd0 || word_count !== 9'd0) begin
            errors++;
            $display("FAIL reload_start: done=%b busy=%b addr=%h cnt=%0d required 0/1/00/0",
                     done, busy, imem_addr, word_count);
        end
        send_prog(0, 2);
        repeat (3) @(negedge clk);
        send_prog(2, 6);
        wait_done(30, cd, hb);
        checks++;
        if (cd - c0 != 13 || hb !== 1'b1) begin
            errors++;
            $display("FAIL stall_timing: cycles=%0d hold_before=%b required 13/1", cd - c0, hb);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL stall_count: writes=%0d required 2", wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00A00093 ||
                     wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00500113) begin
            errors++;
            $display("FAIL stall_words: %h@%h %h@%h required 00A00093@00 00500113@01",
                     wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
        end
    endtask

    task automatic test_zero_len();
        do_reset(1);
        clear_log();
        do_start(9'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || word_count !== 9'd0) begin
            errors++;
            $display("FAIL zero_len: done=%b busy=%b ready=%b cnt=%0d required 1/0/0/0",
                     done, busy, in_ready, word_count);
        end
        @(negedge clk);
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_len_we: writes=%0d required 0", wr_addr.size());
        end
    endtask

    task automatic test_clamp();
        int cd;
        logic hb;
        clear_log();
        do_start(9'd261);
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 4; b++) send_byte(8'(4 * w + b));
        wait_done(20, cd, hb);
        checks++;
        if (wr_addr.size() != 256 || word_count !== 9'd256) begin
            errors++;
            $display("FAIL clamp_count: writes=%0d word_count=%0d required 256/256", wr_addr.size(), word_count);
        end else if (wr_addr[255] !== 8'hFF || wr_data[255] !== 32'hFFFEFDFC || wr_data[0] !== 32'h03020100) begin
            errors++;
            $display("FAIL clamp_last: addr=%h data=%h first=%h required FF/FFFEFDFC/03020100",
                     wr_addr[255], wr_data[255], wr_data[0]);
        end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_addr.size() != 256 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_no_accept: ready=%b writes=%0d done=%b required 0/256/1",
                     in_ready, wr_addr.size(), done);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        int cd;
        logic hb;
        do_reset(1);
        clear_log();
        do_start(9'd3);
        send_prog(0, 6);
        do_reset(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || word_count !== 9'd0 || imem_addr !== 8'd0 || wr_addr.size() != 1) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b cnt=%0d addr=%h writes=%0d required 0/0/0/00/1",
                     busy, done, word_count, imem_addr, wr_addr.size());
        end
        do_start(9'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_done(20, cd, hb);
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL after_reset_count: writes=%0d required 2", wr_addr.size());
        end else if (wr_addr[1] !== 8'd0 || wr_data[1] !== 32'h44332211 || word_count !== 9'd1) begin
            errors++;
            $display("FAIL after_reset_word: %h@%h cnt=%0d required 44332211@00 1",
                     wr_data[1], wr_addr[1], word_count);
        end
    endtask

    task automatic test_busy_start();
        int cd;
        logic hb;
        clear_log();
        do_start(9'd2);
        send_prog(0, 2);
        start     = 1'b1;
        len_words = 9'd1;
        @(negedge clk);
        start     = 1'b0;
        send_prog(2, 6);
        wait_done(30, cd, hb);
        checks++;
        if (wr_addr.size() != 2 || word_count !== 9'd2) begin
            errors++;
            $display("FAIL busy_start: writes=%0d word_count=%0d required 2/2", wr_addr.size(), word_count);
        end else if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00500113 || wr_data[0] !== 32'h00A00093) begin
            errors++;
            $display("FAIL busy_start_words: %h %h@%h required 00A00093 00500113@01",
                     wr_data[0], wr_data[1], wr_addr[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_reload();
        test_zero_len();
        test_clamp();
        test_mid_reset();
        test_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
